// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI slave deserialiser.
//               FSM state encoding, sample-edge selection from CPOL/CPHA,
//               a clog2 helper and the frame word counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Width of the per-frame completed word counter
    localparam int c_FRAME_WORDS_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // 1 = sample MOSI on rising SCLK, 0 = on falling SCLK
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : Synchronous show-ahead FIFO. dout presents the head entry
//               whenever the FIFO is not empty and reads as zero when empty.
//               A push while full is only accepted together with a pop.
//               A pop while empty is ignored.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, din       - write strobe and data
//               pop             - consume head entry
//               dout            - head entry
//               empty, full     - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [P_WIDTH-1:0] din,
    output logic [P_WIDTH-1:0] dout,
    output logic               empty,
    output logic               full
);

    localparam int c_AW = (clog2(P_DEPTH) < 1) ? 1 : clog2(P_DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(P_DEPTH);

    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (c_AW + 1)'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - (c_AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/spi_slave_deser.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_deser
// Description : SPI slave receiver. Oversamples SCLK/CS_n/MOSI in the clk
//               domain, deserialises 1..N MOSI lanes into words (MSB- or
//               LSB-first, all four CPOL/CPHA modes) and buffers them in a
//               show-ahead FIFO with valid/ready output.
// Ports       : clk, rst            - system clock, sync active-high reset
//               spi_sclk_i          - SPI clock (async)
//               spi_cs_n_i          - chip select, active-low (async)
//               spi_mosi_i          - MOSI lanes (async)
//               dout, dout_valid    - FIFO head word / not empty
//               dout_ready          - consumer accepts dout
//               frame_start/end     - one-cycle pulses at CS_n fall/rise
//               frame_words         - completed words in frame (saturating)
//               overflow            - sticky drop flag, overflow_clr clears
//               dout_partial        - only with SPI_PARTIAL_FLUSH_EN
// Options     : define SPI_PARTIAL_FLUSH_EN to flush a partial word at
//               CS_n rise (justified, zero-filled, tagged by dout_partial).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_deser
    import spi_pkg::*;
#(
    parameter int P_DATA_IN_WIDTH   = 1,
    parameter int P_DATA_TEMP_WIDTH = 8,
    parameter int P_FIFO_DEPTH      = 4,
    parameter int P_CPOL            = 0,
    parameter int P_CPHA            = 0,
    parameter int P_MSB_FIRST       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_sclk_i,
    input  logic                         spi_cs_n_i,
    input  logic [P_DATA_IN_WIDTH-1:0]   spi_mosi_i,
    output logic [P_DATA_TEMP_WIDTH-1:0] dout,
    output logic                         dout_valid,
`ifdef SPI_PARTIAL_FLUSH_EN
    output logic                         dout_partial,
`endif
    input  logic                         dout_ready,
    output logic                         frame_start,
    output logic                         frame_end,
    output logic [c_FRAME_WORDS_W-1:0]   frame_words,
    output logic                         overflow,
    input  logic                         overflow_clr
);

    localparam int   c_BEATS       = P_DATA_TEMP_WIDTH / P_DATA_IN_WIDTH;
    localparam int   c_CNT_W       = (clog2(c_BEATS) < 1) ? 1 : clog2(c_BEATS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BEATS - 1);
    localparam logic c_SAMPLE_RISE = sample_on_rise(P_CPOL, P_CPHA);
    localparam logic c_SCLK_IDLE   = (P_CPOL != 0);
`ifdef SPI_PARTIAL_FLUSH_EN
    localparam int   c_FIFO_W      = P_DATA_TEMP_WIDTH + 1;
`else
    localparam int   c_FIFO_W      = P_DATA_TEMP_WIDTH;
`endif

    // ------------------------------------------------------------------
    // Synchronisers and edge detection
    // ------------------------------------------------------------------
    logic                       r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic                       r_cs_s1, r_cs_s2, r_cs_s3;
    logic [P_DATA_IN_WIDTH-1:0] r_mosi_s1, r_mosi_s2, r_mosi_smp;
    logic                       r_smp_edge, r_cs_fall, r_cs_rise;
    logic                       w_sclk_edge;

    assign w_sclk_edge = c_SAMPLE_RISE ? (r_sclk_s2 & ~r_sclk_s3)
                                       : (~r_sclk_s2 & r_sclk_s3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s1  <= c_SCLK_IDLE;
            r_sclk_s2  <= c_SCLK_IDLE;
            r_sclk_s3  <= c_SCLK_IDLE;
            // CS chain resets low: a CS_n already low at reset release then
            // produces no falling edge, while a high CS_n only yields a
            // rising edge, which IDLE ignores.
            r_cs_s1    <= 1'b0;
            r_cs_s2    <= 1'b0;
            r_cs_s3    <= 1'b0;
            r_mosi_s1  <= '0;
            r_mosi_s2  <= '0;
            r_mosi_smp <= '0;
            r_smp_edge <= 1'b0;
            r_cs_fall  <= 1'b0;
            r_cs_rise  <= 1'b0;
        end else begin
            r_sclk_s1  <= spi_sclk_i;
            r_sclk_s2  <= r_sclk_s1;
            r_sclk_s3  <= r_sclk_s2;
            r_cs_s1    <= spi_cs_n_i;
            r_cs_s2    <= r_cs_s1;
            r_cs_s3    <= r_cs_s2;
            r_mosi_s1  <= spi_mosi_i;
            r_mosi_s2  <= r_mosi_s1;
            // MOSI taken from the same stage that reveals the SCLK edge
            r_mosi_smp <= r_mosi_s2;
            r_smp_edge <= w_sclk_edge;
            r_cs_fall  <= ~r_cs_s2 & r_cs_s3;
            r_cs_rise  <= r_cs_s2 & ~r_cs_s3;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and shifter
    // ------------------------------------------------------------------
    spi_state_e                   r_state, w_state_next;
    logic [P_DATA_TEMP_WIDTH-1:0] r_shift, w_shift_next;
    logic [c_CNT_W-1:0]           r_cnt, w_cnt_next;
    logic [c_FRAME_WORDS_W-1:0]   r_frame_words, w_words_next;
    logic                         r_frame_start, w_frame_start_next;
    logic                         r_frame_end, w_frame_end_next;
    logic                         r_push, w_push_next;
    logic [P_DATA_TEMP_WIDTH-1:0] r_push_data, w_push_data_next;
`ifdef SPI_PARTIAL_FLUSH_EN
    logic                         r_push_partial, w_push_partial_next;
    int                           w_just_amt;
`endif

    always_comb begin
        w_state_next       = r_state;
        w_shift_next       = r_shift;
        w_cnt_next         = r_cnt;
        w_words_next       = r_frame_words;
        w_frame_start_next = 1'b0;
        w_frame_end_next   = 1'b0;
        w_push_next        = 1'b0;
        w_push_data_next   = r_push_data;
`ifdef SPI_PARTIAL_FLUSH_EN
        w_push_partial_next = 1'b0;
        w_just_amt          = 0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_cs_fall) begin
                    w_state_next       = ST_SHIFT;
                    w_frame_start_next = 1'b1;
                    w_shift_next       = '0;
                    w_cnt_next         = '0;
                    w_words_next       = '0;
                end
            end
            ST_SHIFT: begin
                // Sample edge is handled before CS rise so a final beat
                // coinciding with CS_n rise still completes its word.
                if (r_smp_edge) begin
                    if (P_MSB_FIRST != 0) begin
                        w_shift_next = (r_shift << P_DATA_IN_WIDTH)
                                     | P_DATA_TEMP_WIDTH'(r_mosi_smp);
                    end else begin
                        w_shift_next = (r_shift >> P_DATA_IN_WIDTH)
                                     | (P_DATA_TEMP_WIDTH'(r_mosi_smp)
                                        << (P_DATA_TEMP_WIDTH - P_DATA_IN_WIDTH));
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_next       = '0;
                        w_push_next      = 1'b1;
                        w_push_data_next = w_shift_next;
                        if (r_frame_words != '1) begin
                            w_words_next = r_frame_words + c_FRAME_WORDS_W'(1);
                        end
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
                if (r_cs_rise) begin
                    w_frame_end_next = 1'b1;
                    w_state_next     = ST_IDLE;
`ifdef SPI_PARTIAL_FLUSH_EN
                    if (w_cnt_next != '0) begin
                        // Move received beats to the end the first beat
                        // would occupy in a full word; vacated bits are zero.
                        w_just_amt = (c_BEATS - int'(w_cnt_next)) * P_DATA_IN_WIDTH;
                        if (P_MSB_FIRST != 0) begin
                            w_push_data_next = w_shift_next << w_just_amt;
                        end else begin
                            w_push_data_next = w_shift_next >> w_just_amt;
                        end
                        w_push_next         = 1'b1;
                        w_push_partial_next = 1'b1;
                    end
`endif
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_frame_words  <= '0;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_push         <= 1'b0;
            r_push_data    <= '0;
`ifdef SPI_PARTIAL_FLUSH_EN
            r_push_partial <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_next;
            r_shift        <= w_shift_next;
            r_cnt          <= w_cnt_next;
            r_frame_words  <= w_words_next;
            r_frame_start  <= w_frame_start_next;
            r_frame_end    <= w_frame_end_next;
            r_push         <= w_push_next;
            r_push_data    <= w_push_data_next;
`ifdef SPI_PARTIAL_FLUSH_EN
            r_push_partial <= w_push_partial_next;
`endif
        end
    end

    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign frame_words = r_frame_words;

    // ------------------------------------------------------------------
    // Output FIFO and overflow tracking
    // ------------------------------------------------------------------
    logic [c_FIFO_W-1:0] w_fifo_din, w_fifo_dout;
    logic                w_empty, w_full, w_pop, w_drop;
    logic                r_overflow;

`ifdef SPI_PARTIAL_FLUSH_EN
    assign w_fifo_din   = {r_push_partial, r_push_data};
    assign dout         = w_fifo_dout[P_DATA_TEMP_WIDTH-1:0];
    assign dout_partial = w_fifo_dout[P_DATA_TEMP_WIDTH];
`else
    assign w_fifo_din   = r_push_data;
    assign dout         = w_fifo_dout;
`endif

    assign dout_valid = ~w_empty;
    assign w_pop      = dout_valid & dout_ready;
    assign w_drop     = r_push & w_full & ~w_pop;

    spi_rx_fifo #(
        .P_WIDTH (c_FIFO_W),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    // A new drop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_deser
// Description : Directed self-checking bench. Three DUTs share one SPI bus
//               and are selected through gated chip selects:
//                 u_dut0 - mode 0, 1 lane, 8 bit, MSB-first, depth 4
//                 u_dut1 - mode 3, 1 lane, 8 bit, LSB-first
//                 u_dut2 - mode 1, 4 lanes, 16 bit, MSB-first
//               The bus clock is driven in mode-0 shape; CPOL=1 DUTs see it
//               inverted. MOSI changes mid low phase so it is stable
//               around both edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_deser;

    localparam int C_Q = 10;  // quarter SCLK period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       base_sclk;
    logic       cs_bus;
    logic [3:0] mosi_bus;
    logic [2:0] sel;
    logic       cs0, cs1, cs2, sclk1;

    assign cs0   = cs_bus | ~sel[0];
    assign cs1   = cs_bus | ~sel[1];
    assign cs2   = cs_bus | ~sel[2];
    assign sclk1 = ~base_sclk;

    logic [7:0]  dout0, dout1;
    logic [15:0] dout2;
    logic        dout_valid0, dout_valid1, dout_valid2;
    logic        dout_ready0, dout_ready1, dout_ready2;
    logic        frame_start0, frame_start1, frame_start2;
    logic        frame_end0, frame_end1, frame_end2;
    logic [15:0] frame_words0, frame_words1, frame_words2;
    logic        overflow0, overflow1, overflow2;
    logic        overflow_clr0;
`ifdef SPI_PARTIAL_FLUSH_EN
    logic        dout_partial0, dout_partial1, dout_partial2;
`endif

    spi_slave_deser u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk_i   (base_sclk),
        .spi_cs_n_i   (cs0),
        .spi_mosi_i   (mosi_bus[0]),
        .dout         (dout0),
        .dout_valid   (dout_valid0),
`ifdef SPI_PARTIAL_FLUSH_EN
        .dout_partial (dout_partial0),
`endif
        .dout_ready   (dout_ready0),
        .frame_start  (frame_start0),
        .frame_end    (frame_end0),
        .frame_words  (frame_words0),
        .overflow     (overflow0),
        .overflow_clr (overflow_clr0)
    );

    spi_slave_deser #(
        .P_CPOL      (1),
        .P_CPHA      (1),
        .P_MSB_FIRST (0)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk_i   (sclk1),
        .spi_cs_n_i   (cs1),
        .spi_mosi_i   (mosi_bus[0]),
        .dout         (dout1),
        .dout_valid   (dout_valid1),
`ifdef SPI_PARTIAL_FLUSH_EN
        .dout_partial (dout_partial1),
`endif
        .dout_ready   (dout_ready1),
        .frame_start  (frame_start1),
        .frame_end    (frame_end1),
        .frame_words  (frame_words1),
        .overflow     (overflow1),
        .overflow_clr (1'b0)
    );

    spi_slave_deser #(
        .P_DATA_IN_WIDTH   (4),
        .P_DATA_TEMP_WIDTH (16),
        .P_CPHA            (1)
    ) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk_i   (base_sclk),
        .spi_cs_n_i   (cs2),
        .spi_mosi_i   (mosi_bus),
        .dout         (dout2),
        .dout_valid   (dout_valid2),
`ifdef SPI_PARTIAL_FLUSH_EN
        .dout_partial (dout_partial2),
`endif
        .dout_ready   (dout_ready2),
        .frame_start  (frame_start2),
        .frame_end    (frame_end2),
        .frame_words  (frame_words2),
        .overflow     (overflow2),
        .overflow_clr (1'b0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int fs0 = 0, fe0 = 0, fs1 = 0, fe1 = 0;
    int lat;

    always @(negedge clk) begin
        if (frame_start0) fs0++;
        if (frame_end0)   fe0++;
        if (frame_start1) fs1++;
        if (frame_end1)   fe1++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic spi_beat(input logic [3:0] v);
        repeat (C_Q) @(negedge clk);
        mosi_bus = v;
        repeat (C_Q) @(negedge clk);
        base_sclk = 1'b1;
        repeat (2 * C_Q) @(negedge clk);
        base_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] val, input int nbits, input bit lsb_first);
        for (int i = 0; i < nbits; i++) begin
            if (lsb_first) spi_beat({3'b000, val[i]});
            else           spi_beat({3'b000, val[nbits-1-i]});
        end
    endtask

    task automatic frame_open();
        cs_bus = 1'b0;
        repeat (C_Q) @(negedge clk);
    endtask

    task automatic frame_close();
        repeat (C_Q) @(negedge clk);
        cs_bus = 1'b1;
        repeat (2 * C_Q) @(negedge clk);
    endtask

    task automatic pop0();
        dout_ready0 = 1'b1;
        @(negedge clk);
        dout_ready0 = 1'b0;
    endtask

    task automatic pop1();
        dout_ready1 = 1'b1;
        @(negedge clk);
        dout_ready1 = 1'b0;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        base_sclk     = 1'b0;
        cs_bus        = 1'b1;
        mosi_bus      = 4'h0;
        sel           = 3'b000;
        dout_ready0   = 1'b0;
        dout_ready1   = 1'b0;
        dout_ready2   = 1'b0;
        overflow_clr0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_dout",        dout0,        0);
        check("rst_dout_valid",  dout_valid0,  0);
        check("rst_frame_start", frame_start0, 0);
        check("rst_frame_end",   frame_end0,   0);
        check("rst_frame_words", frame_words0, 0);
        check("rst_overflow",    overflow0,    0);

        // Mode 0, 0xA5, measure latency from final rising SCLK
        sel = 3'b001;
        frame_open();
        send_bits(16'h0052, 7, 1'b0);
        repeat (C_Q) @(negedge clk);
        mosi_bus = 4'h1;
        repeat (C_Q) @(negedge clk);
        base_sclk = 1'b1;
        lat = 0;
        @(negedge clk);
        while (!dout_valid0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", lat, 4);
        repeat (C_Q) @(negedge clk);
        base_sclk = 1'b0;
        frame_close();
        check("t1_dout",        dout0,        8'hA5);
        check("t1_frame_words", frame_words0, 1);
        check("t1_frame_start", fs0,          1);
        pop0();
        check("t1_empty", dout_valid0, 0);

        // Mode 3, LSB-first, two bytes in one frame
        sel = 3'b010;
        frame_open();
        send_bits(16'h003C, 8, 1'b1);
        send_bits(16'h0081, 8, 1'b1);
        frame_close();
        check("t2_frame_start_cnt", fs1,          1);
        check("t2_frame_end_cnt",   fe1,          1);
        check("t2_frame_words",     frame_words1, 2);
        check("t2_valid",           dout_valid1,  1);
        check("t2_word0",           dout1,        8'h3C);
        pop1();
        check("t2_word1",           dout1,        8'h81);
        pop1();
        check("t2_empty",           dout_valid1,  0);

        // Mode 1, 4 lanes, 16-bit word
        sel = 3'b100;
        frame_open();
        spi_beat(4'h1);
        spi_beat(4'h2);
        spi_beat(4'h3);
        spi_beat(4'h4);
        frame_close();
        check("t3_valid",       dout_valid2,  1);
        check("t3_dout",        dout2,        16'h1234);
        check("t3_frame_words", frame_words2, 1);

        // Overflow: 5 bytes into depth 4 with no consumer
        sel = 3'b001;
        frame_open();
        for (int i = 1; i <= 5; i++) send_bits(16'(i), 8, 1'b0);
        frame_close();
        check("t4_overflow_set", overflow0,    1);
        check("t4_frame_words",  frame_words0, 5);
        overflow_clr0 = 1'b1;
        @(negedge clk);
        overflow_clr0 = 1'b0;
        check("t4_overflow_clr", overflow0, 0);
        for (int i = 1; i <= 4; i++) begin
            check("t4_drain_valid", dout_valid0, 1);
            check("t4_drain_data",  dout0,       8'(i));
            pop0();
        end
        check("t4_drained", dout_valid0, 0);

        // Partial word: 5 of 8 bits of 0xFF
        fe0 = 0;
        frame_open();
        send_bits(16'h001F, 5, 1'b0);
        frame_close();
        check("t5_frame_end_cnt", fe0,          1);
        check("t5_frame_words",   frame_words0, 0);
`ifdef SPI_PARTIAL_FLUSH_EN
        check("t5_valid",   dout_valid0,   1);
        check("t5_dout",    dout0,         8'hF8);
        check("t5_partial", dout_partial0, 1);
        pop0();
        check("t5_empty",   dout_valid0,   0);
`else
        check("t5_no_word", dout_valid0,   0);
`endif

        // Reset mid-frame with CS_n held low
        frame_open();
        send_bits(16'h0077, 8, 1'b0);
        repeat (6) @(negedge clk);
        check("t6_pre_valid",       dout_valid0,  1);
        check("t6_pre_frame_words", frame_words0, 1);
        send_bits(16'h0002, 3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_dout",        dout0,        0);
        check("t6_rst_valid",       dout_valid0,  0);
        check("t6_rst_frame_words", frame_words0, 0);
        check("t6_rst_overflow",    overflow0,    0);
        check("t6_rst_frame_start", frame_start0, 0);
        check("t6_rst_frame_end",   frame_end0,   0);
        send_bits(16'h001A, 5, 1'b0);
        frame_close();
        check("t6_no_word",         dout_valid0,  0);
        check("t6_no_frame_words",  frame_words0, 0);
        frame_open();
        send_bits(16'h005A, 8, 1'b0);
        frame_close();
        check("t6_new_valid",       dout_valid0,  1);
        check("t6_new_dout",        dout0,        8'h5A);
        check("t6_new_frame_words", frame_words0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
